// File: rtl/conv_output_streamer_if.sv
// Streaming output bus of conv_output_streamer: one 32-bit feature-map word
// per valid/ready handshake, tagged with its filter/pixel position and
// end-of-map / end-of-frame markers.
interface conv_output_streamer_if #(
  parameter int FW = 4,  // filter index width
  parameter int PW = 7   // pixel index width
);
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready;
  logic [FW-1:0] m_filter_idx;
  logic [PW-1:0] m_pix_idx;
  logic          m_last_map;
  logic          m_last;

  modport master (
    output m_data, m_valid, m_filter_idx, m_pix_idx, m_last_map, m_last,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_filter_idx, m_pix_idx, m_last_map, m_last,
    output m_ready
  );
endinterface

// File: rtl/conv_output_streamer.sv
// conv_output_streamer: snapshots a conv layer's full feature-map bank on a
// start pulse and drains it as a filter-major, row-major word stream over a
// valid/ready bus. All outputs are registered; a stall holds them stable.
// Optional feature: define RELU_OUT_EN to clamp negative words to zero at the
// output mux (indices and flags unchanged).
module conv_output_streamer #(
  parameter int num_filters = 16,
  parameter int input_size  = 28,
  parameter int filter_size = 7,
  parameter int stride      = 2,
  localparam int OUT_DIM  = ((input_size - filter_size) / stride) + 1,
  localparam int MAP_SIZE = OUT_DIM * OUT_DIM,
  localparam int FW       = (num_filters > 1) ? $clog2(num_filters) : 1,
  localparam int PW       = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          conv_in [num_filters][MAP_SIZE],
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  conv_output_streamer_if.master m
);

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t      state;
  logic [31:0] snap [num_filters][MAP_SIZE];

  logic [FW-1:0] next_f;
  logic [PW-1:0] next_p;
  logic          next_last_map;
  logic          next_last;

  // Output-stage word transform: optional ReLU on the emitted value.
  function automatic logic [31:0] out_word(input logic [31:0] w);
`ifdef RELU_OUT_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  // Position of the word following the one currently presented.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    next_f = m.m_filter_idx;
    next_p = m.m_pix_idx + PW'(1);
    if (m.m_last_map) begin
      next_p = '0;
      next_f = m.m_filter_idx + FW'(1);
    end
    next_last_map = (next_p == PW'(MAP_SIZE - 1));
    next_last     = next_last_map && (next_f == FW'(num_filters - 1));
  end

  // Snapshot bank: frozen copy of conv_in taken when a start is accepted.
  // NOTE: the bank is a memory and deliberately has no reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (rst_n && state == IDLE && start) begin
      snap <= conv_in;
    end
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      m.m_valid      <= 1'b0;
      m.m_data       <= '0;
      m.m_filter_idx <= '0;
      m.m_pix_idx    <= '0;
      m.m_last_map   <= 1'b0;
      m.m_last       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= STREAM;
            busy           <= 1'b1;
            m.m_valid      <= 1'b1;
            // The bank is being loaded this same edge, so the first word comes straight from conv_in.
            m.m_data       <= out_word(conv_in[0][0]);
            m.m_filter_idx <= '0;
            m.m_pix_idx    <= '0;
            m.m_last_map   <= (MAP_SIZE == 1);
            m.m_last       <= (MAP_SIZE == 1) && (num_filters == 1);
          end
        end
        STREAM: begin
          if (m.m_valid && m.m_ready) begin
            if (m.m_last) begin
              state        <= IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
              m.m_valid    <= 1'b0;
              m.m_last     <= 1'b0;
              m.m_last_map <= 1'b0;
            end else begin
              m.m_filter_idx <= next_f;
              m.m_pix_idx    <= next_p;
              m.m_data       <= out_word(snap[next_f][next_p]);
              m.m_last_map   <= next_last_map;
              m.m_last       <= next_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_output_streamer.sv
// Scoreboard bench for conv_output_streamer: each accepted start pushes the
// whole expected frame (computed from the bank contents) into a queue; an
// independent monitor compares every presented beat against the queue head.
module tb_conv_output_streamer;

  localparam int NF    = 16;
  localparam int MAP   = 121;
  localparam int TOTAL = NF * MAP;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  f;
    logic [6:0]  p;
    logic        lm;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] conv_in [NF][MAP];
  logic [31:0] bank    [NF][MAP];

  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    beat  = 0;
  int    valid_cycles = 0;
  int    mode  = 0;
  bit    mon_en = 1'b0;
  bit    done_exp = 1'b0;

  conv_output_streamer_if #(.FW(4), .PW(7)) s_if ();

  conv_output_streamer #(
    .num_filters(NF), .input_size(28), .filter_size(7), .stride(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .conv_in(conv_in), .start(start),
    .busy(busy), .done(done), .m(s_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef RELU_OUT_EN
    return ($signed(w) < 0) ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  // Expected frame: every map in filter order, pixels in raster order.
  task automatic push_frame();
    beat_t e;
    for (int f = 0; f < NF; f++) begin
      for (int p = 0; p < MAP; p++) begin
        e.d  = model_word(bank[f][p]);
        e.f  = 4'(f);
        e.p  = 7'(p);
        e.lm = (p == MAP - 1);
        e.l  = (f == NF - 1) && (p == MAP - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Called just after a posedge; the start is taken at the next edge.
  task automatic start_frame();
    start = 1'b1;
    @(posedge clk);
    push_frame();
    beat = 0;
    valid_cycles = 0;
    #1 start = 1'b0;
  endtask

  // Returns at the edge of the final handshake (the done cycle follows).
  task automatic wait_frame();
    int n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("frame_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_beat(input int b);
    int n = 0;
    while (beat < b && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("beat_timeout", 64'(beat >= b), 64'd1);
  endtask

  task automatic fill_ramp();
    for (int f = 0; f < NF; f++)
      for (int p = 0; p < MAP; p++)
        bank[f][p] = 32'(f * 1000 + p);
  endtask

  task automatic fill_random();
    for (int f = 0; f < NF; f++)
      for (int p = 0; p < MAP; p++)
        bank[f][p] = $urandom;
  endtask

  task automatic load_bank();
    for (int f = 0; f < NF; f++)
      for (int p = 0; p < MAP; p++)
        conv_in[f][p] = bank[f][p];
  endtask

  // Downstream ready: always high, or a fair coin per cycle.
  always @(posedge clk) begin
    #2;
    s_if.m_ready = (mode == 0) ? 1'b1 : 1'($urandom & 1);
  end

  // Monitor: sampled at the falling edge, between handshake edges.
  always @(negedge clk) begin
    beat_t got;
    if (mon_en) begin
      check("valid", 64'(s_if.m_valid), 64'(sb.size() != 0));
      check("busy", 64'(busy), 64'(sb.size() != 0));
      check("done", 64'(done), 64'(done_exp));
      done_exp = 1'b0;
      if (s_if.m_valid && sb.size() != 0) begin
        got = '{d: s_if.m_data, f: s_if.m_filter_idx, p: s_if.m_pix_idx,
                lm: s_if.m_last_map, l: s_if.m_last};
        check($sformatf("beat%0d", beat), 64'(got), 64'(sb[0]));
        valid_cycles++;
        if (s_if.m_ready) begin
          if (sb[0].l) done_exp = 1'b1;
          void'(sb.pop_front());
          beat++;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    s_if.m_ready = 1'b1;
    for (int f = 0; f < NF; f++)
      for (int p = 0; p < MAP; p++)
        conv_in[f][p] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(s_if.m_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fidx", 64'(s_if.m_filter_idx), 64'd0);
    check("rst_pidx", 64'(s_if.m_pix_idx), 64'd0);
    check("rst_data", 64'(s_if.m_data), 64'd0);
    check("rst_last", 64'({s_if.m_last, s_if.m_last_map}), 64'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Full-rate ramp frame
    mode = 0;
    fill_ramp();
    load_bank();
    start_frame();
    wait_frame();
    check("throughput", 64'(valid_cycles), 64'(TOTAL));

    // Back-to-back: start issued in the done cycle, negative word at beat 368
    #1;
    fill_ramp();
    bank[3][5] = 32'hFFFF_FFF6;
    load_bank();
    start_frame();
    wait_frame();
    check("throughput2", 64'(valid_cycles), 64'(TOTAL));
    repeat (3) @(posedge clk);
    #1;

    // Random data with random backpressure
    mode = 1;
    fill_random();
    load_bank();
    start_frame();
    wait_frame();
    repeat (3) @(posedge clk);
    #1;

    // Snapshot isolation: input bank trashed right after capture
    fill_random();
    load_bank();
    start_frame();
    for (int f = 0; f < NF; f++)
      for (int p = 0; p < MAP; p++)
        conv_in[f][p] = 32'hDEAD_BEEF;
    wait_frame();
    repeat (3) @(posedge clk);
    #1;

    // Abuse: start mid-stream ignored, reset mid-stream aborts, restart
    fill_random();
    load_bank();
    start_frame();
    wait_beat(10);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_beat(500);
    #1 rst_n = 1'b0;
    @(posedge clk);
    sb.delete();
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_frame();
    wait_frame();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
